// File: rtl/hier_collect_pkg.sv
// ---------------------------------------------------------------------------
// hier_collect_pkg
// Shared definitions for the hierarchical fan-in collector family.
//   - default N_CHILD / DATA_W / SRC_W / CNT_W constants
//   - pick_t : result of a round-robin search {found, idx}
//   - beat_t : upstream beat {src, data} at the default widths
//   - rr_pick: round-robin search of a valid vector starting at ptr
// ---------------------------------------------------------------------------
package hier_collect_pkg;

    localparam int unsigned N_CHILD_DEF = 5;
    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned SRC_W_DEF   = 3;
    localparam int unsigned CNT_W_DEF   = 16;

    // Largest supported child count and the index width that covers it.
    localparam int unsigned MAX_CHILD   = 8;
    localparam int unsigned PICK_W      = 3;

    typedef struct packed {
        logic              found;
        logic [PICK_W-1:0] idx;
    } pick_t;

    typedef struct packed {
        logic [SRC_W_DEF-1:0]  src;
        logic [DATA_W_DEF-1:0] data;
    } beat_t;

    // Searches valid[] from ptr upwards, wrapping at n-1 -> 0.
    // Only the first n entries take part; ptr is expected to be < n.
    function automatic pick_t rr_pick(
        input logic [MAX_CHILD-1:0] valid,
        input logic [PICK_W-1:0]    ptr,
        input int unsigned          n
    );
        pick_t       r;
        int unsigned idx;
        r = '0;
        for (int unsigned k = 0; k < MAX_CHILD; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((k < n) && !r.found && valid[idx[PICK_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = idx[PICK_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter.
// Ports:
//   valid     in  N      request vector
//   ptr       in  IDX_W  index with highest priority this cycle
//   grant     out N      one-hot grant, zero when nothing is valid
//   grant_idx out IDX_W  binary index of the granted request
//   grant_vld out 1      a request was granted
// ---------------------------------------------------------------------------
module rr_arbiter
    import hier_collect_pkg::*;
#(
    parameter int unsigned N     = N_CHILD_DEF,
    parameter int unsigned IDX_W = SRC_W_DEF
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_vld
);

    logic [MAX_CHILD-1:0] valid_ext;
    logic [PICK_W-1:0]    ptr_n;
    pick_t                pick;

    always_comb begin
        valid_ext = MAX_CHILD'(valid);
        ptr_n     = PICK_W'(ptr);
        pick      = rr_pick(valid_ext, ptr_n, N);
        grant     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            grant[i] = pick.found && (32'(pick.idx) == i);
        end
        grant_idx = IDX_W'(pick.idx);
        grant_vld = pick.found;
    end

endmodule

// File: rtl/hier_fanin_collector.sv
// ---------------------------------------------------------------------------
// hier_fanin_collector
// Merges result beats from N_CHILD children into one registered upstream
// valid/ready channel, tagging each beat with its source index and tracking
// which children have reported during the current sweep.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   child_valid  in  per-child beat valid
//   child_data   in  packed payloads, child i at [i*DATA_W +: DATA_W]
//   child_ready  out per-child accept (one-hot or zero)
//   up_valid     out upstream beat valid
//   up_data      out upstream payload
//   up_src       out index of the child that produced up_data
//   up_ready     in  upstream accept
//   sweep_clr    in  clears the seen mask
//   seen_mask    out children accepted since last clear/completion
//   sweep_done   out one-cycle pulse when every child has reported
//   beat_cnt     out saturating count of upstream handshakes
// ---------------------------------------------------------------------------
module hier_fanin_collector
    import hier_collect_pkg::*;
#(
    parameter int unsigned N_CHILD = N_CHILD_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned SRC_W   = SRC_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_CHILD-1:0]        child_valid,
    input  logic [N_CHILD*DATA_W-1:0] child_data,
    output logic [N_CHILD-1:0]        child_ready,
    output logic                      up_valid,
    output logic [DATA_W-1:0]         up_data,
    output logic [SRC_W-1:0]          up_src,
    input  logic                      up_ready,
    input  logic                      sweep_clr,
    output logic [N_CHILD-1:0]        seen_mask,
    output logic                      sweep_done,
    output logic [CNT_W-1:0]          beat_cnt
);

    typedef struct packed {
        logic [SRC_W-1:0]  src;
        logic [DATA_W-1:0] data;
    } out_beat_t;

    out_beat_t          beat_q, beat_d;
    logic               up_valid_q, up_valid_d;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [N_CHILD-1:0] seen_mask_q, seen_mask_d;
    logic               sweep_done_q, sweep_done_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic [N_CHILD-1:0] grant;
    logic [SRC_W-1:0]   grant_idx;
    logic               grant_vld;
    logic               load_en;
    logic               child_hs;
    logic [DATA_W-1:0]  sel_data;
    logic [N_CHILD-1:0] seen_next;

    rr_arbiter #(
        .N     (N_CHILD),
        .IDX_W (SRC_W)
    ) u_arb (
        .valid     (child_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // Output register may take a new beat when empty or draining this cycle.
    assign load_en  = !up_valid_q || up_ready;
    // Gating with rst_n keeps children pending while reset is asserted.
    assign child_hs = rst_n && load_en && grant_vld;

    always_comb begin
        child_ready = '0;
        if (rst_n && load_en) begin
            child_ready = grant;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N_CHILD; i++) begin
            if (grant[i]) begin
                sel_data = child_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        up_valid_d = up_valid_q;
        beat_d     = beat_q;
        rr_ptr_d   = rr_ptr_q;
        if (load_en) begin
            if (child_hs) begin
                up_valid_d  = 1'b1;
                beat_d.src  = grant_idx;
                beat_d.data = sel_data;
                if (grant_idx == SRC_W'(N_CHILD - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = grant_idx + SRC_W'(1);
                end
            end else begin
                up_valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (up_valid_q && up_ready && (beat_cnt_q != '1)) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
    end

    // A handshake landing in the same cycle as sweep_clr survives the clear.
    always_comb begin
        seen_next = sweep_clr ? '0 : seen_mask_q;
        if (child_hs) begin
            seen_next = seen_next | grant;
        end
        if (seen_next == '1) begin
            sweep_done_d = 1'b1;
            seen_mask_d  = '0;
        end else begin
            sweep_done_d = 1'b0;
            seen_mask_d  = seen_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            up_valid_q   <= 1'b0;
            beat_q       <= '0;
            rr_ptr_q     <= '0;
            seen_mask_q  <= '0;
            sweep_done_q <= 1'b0;
            beat_cnt_q   <= '0;
        end else begin
            up_valid_q   <= up_valid_d;
            beat_q       <= beat_d;
            rr_ptr_q     <= rr_ptr_d;
            seen_mask_q  <= seen_mask_d;
            sweep_done_q <= sweep_done_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign up_valid   = up_valid_q;
    assign up_data    = beat_q.data;
    assign up_src     = beat_q.src;
    assign seen_mask  = seen_mask_q;
    assign sweep_done = sweep_done_q;
    assign beat_cnt   = beat_cnt_q;

endmodule

// File: tb/tb_hier_fanin_collector.sv
module tb_hier_fanin_collector;

    localparam int unsigned N  = 5;
    localparam int unsigned DW = 16;
    localparam int unsigned SW = 3;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    child_valid;
    logic [N*DW-1:0] child_data;
    logic            up_ready;
    logic            sweep_clr;

    logic [N-1:0]    child_ready;
    logic            up_valid;
    logic [DW-1:0]   up_data;
    logic [SW-1:0]   up_src;
    logic [N-1:0]    seen_mask;
    logic            sweep_done;
    logic [15:0]     beat_cnt;

    logic [N-1:0]    s_child_ready;
    logic            s_up_valid;
    logic [DW-1:0]   s_up_data;
    logic [SW-1:0]   s_up_src;
    logic [N-1:0]    s_seen_mask;
    logic            s_sweep_done;
    logic [3:0]      s_beat_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    hier_fanin_collector u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .child_valid (child_valid),
        .child_data  (child_data),
        .child_ready (child_ready),
        .up_valid    (up_valid),
        .up_data     (up_data),
        .up_src      (up_src),
        .up_ready    (up_ready),
        .sweep_clr   (sweep_clr),
        .seen_mask   (seen_mask),
        .sweep_done  (sweep_done),
        .beat_cnt    (beat_cnt)
    );

    hier_fanin_collector #(.CNT_W(4)) u_dut_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .child_valid (child_valid),
        .child_data  (child_data),
        .child_ready (s_child_ready),
        .up_valid    (s_up_valid),
        .up_data     (s_up_data),
        .up_src      (s_up_src),
        .up_ready    (up_ready),
        .sweep_clr   (sweep_clr),
        .seen_mask   (s_seen_mask),
        .sweep_done  (s_sweep_done),
        .beat_cnt    (s_beat_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_default_data();
        for (int i = 0; i < N; i++) begin
            child_data[i*DW +: DW] = 16'hA000 + 16'(i);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        child_valid = 5'b11111;
        up_ready    = 1'b1;
        sweep_clr   = 1'b0;
        set_default_data();
        cyc();
        cyc();
        n_checks++; if (up_valid !== 1'b0) begin n_fail++; $display("FAIL reset_up_valid got %0b want 0", up_valid); end
        n_checks++; if (up_data !== 16'h0) begin n_fail++; $display("FAIL reset_up_data got %h want 0000", up_data); end
        n_checks++; if (up_src !== 3'd0) begin n_fail++; $display("FAIL reset_up_src got %0d want 0", up_src); end
        n_checks++; if (seen_mask !== 5'b0) begin n_fail++; $display("FAIL reset_seen_mask got %b want 00000", seen_mask); end
        n_checks++; if (sweep_done !== 1'b0) begin n_fail++; $display("FAIL reset_sweep_done got %0b want 0", sweep_done); end
        n_checks++; if (beat_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_beat_cnt got %0d want 0", beat_cnt); end
        n_checks++; if (child_ready !== 5'b0) begin n_fail++; $display("FAIL reset_child_ready got %b want 00000", child_ready); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (child_ready !== 5'b00001) begin n_fail++; $display("FAIL first_grant got %b want 00001", child_ready); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_seen;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            if (k == 5)      exp_seen = 5'b00000;
            else if (k == 6) exp_seen = 5'b00001;
            else             exp_seen = 5'((1 << k) - 1);
            n_checks++; if (up_valid !== 1'b1) begin n_fail++; $display("FAIL rr_up_valid[%0d] got %0b want 1", k, up_valid); end
            n_checks++; if (up_src !== 3'((k - 1) % 5)) begin n_fail++; $display("FAIL rr_up_src[%0d] got %0d want %0d", k, up_src, (k - 1) % 5); end
            n_checks++; if (up_data !== 16'hA000 + 16'((k - 1) % 5)) begin n_fail++; $display("FAIL rr_up_data[%0d] got %h want %h", k, up_data, 16'hA000 + 16'((k - 1) % 5)); end
            n_checks++; if (beat_cnt !== 16'(k - 1)) begin n_fail++; $display("FAIL rr_beat_cnt[%0d] got %0d want %0d", k, beat_cnt, k - 1); end
            n_checks++; if (sweep_done !== (k == 5)) begin n_fail++; $display("FAIL rr_sweep_done[%0d] got %0b want %0b", k, sweep_done, k == 5); end
            n_checks++; if (seen_mask !== exp_seen) begin n_fail++; $display("FAIL rr_seen_mask[%0d] got %b want %b", k, seen_mask, exp_seen); end
        end
    endtask

    task automatic test_backpressure();
        child_valid = 5'b00000;
        cyc();
        n_checks++; if (up_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain_valid got %0b want 0", up_valid); end
        child_valid = 5'b00100;
        child_data[2*DW +: DW] = 16'h1234;
        up_ready = 1'b0;
        #1;
        n_checks++; if (child_ready !== 5'b00100) begin n_fail++; $display("FAIL bp_grant2 got %b want 00100", child_ready); end
        cyc();
        child_valid = 5'b01000;
        child_data[3*DW +: DW] = 16'h5678;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++; if (up_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d] got %0b want 1", c, up_valid); end
            n_checks++; if (up_data !== 16'h1234) begin n_fail++; $display("FAIL bp_hold_data[%0d] got %h want 1234", c, up_data); end
            n_checks++; if (up_src !== 3'd2) begin n_fail++; $display("FAIL bp_hold_src[%0d] got %0d want 2", c, up_src); end
            n_checks++; if (child_ready !== 5'b00000) begin n_fail++; $display("FAIL bp_hold_ready[%0d] got %b want 00000", c, child_ready); end
            cyc();
        end
        up_ready = 1'b1;
        #1;
        n_checks++; if (child_ready !== 5'b01000) begin n_fail++; $display("FAIL bp_release_ready got %b want 01000", child_ready); end
        cyc();
        child_valid = 5'b00000;
        n_checks++; if (up_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid got %0b want 1", up_valid); end
        n_checks++; if (up_src !== 3'd3) begin n_fail++; $display("FAIL bp_next_src got %0d want 3", up_src); end
        n_checks++; if (up_data !== 16'h5678) begin n_fail++; $display("FAIL bp_next_data got %h want 5678", up_data); end
        n_checks++; if (beat_cnt !== 16'd7) begin n_fail++; $display("FAIL bp_beat_cnt got %0d want 7", beat_cnt); end
        set_default_data();
        cyc();
    endtask

    task automatic test_sparse_wrap();
        rst_n = 1'b0;
        child_valid = 5'b00000;
        cyc();
        rst_n = 1'b1;
        child_valid = 5'b01000;
        #1;
        n_checks++; if (child_ready !== 5'b01000) begin n_fail++; $display("FAIL sp_grant3 got %b want 01000", child_ready); end
        cyc();
        n_checks++; if (up_src !== 3'd3) begin n_fail++; $display("FAIL sp_src3 got %0d want 3", up_src); end
        n_checks++; if (up_data !== 16'hA003) begin n_fail++; $display("FAIL sp_data3 got %h want a003", up_data); end
        child_valid = 5'b11111;
        #1;
        n_checks++; if (child_ready !== 5'b10000) begin n_fail++; $display("FAIL sp_ptr4 got %b want 10000", child_ready); end
        child_valid = 5'b00010;
        #1;
        n_checks++; if (child_ready !== 5'b00010) begin n_fail++; $display("FAIL sp_wrap_grant1 got %b want 00010", child_ready); end
        cyc();
        n_checks++; if (up_src !== 3'd1) begin n_fail++; $display("FAIL sp_src1 got %0d want 1", up_src); end
        n_checks++; if (seen_mask !== 5'b01010) begin n_fail++; $display("FAIL sp_seen got %b want 01010", seen_mask); end
        n_checks++; if (sweep_done !== 1'b0) begin n_fail++; $display("FAIL sp_done got %0b want 0", sweep_done); end
        child_valid = 5'b11111;
        #1;
        n_checks++; if (child_ready !== 5'b00100) begin n_fail++; $display("FAIL sp_ptr2 got %b want 00100", child_ready); end
        child_valid = 5'b00000;
        cyc();
    endtask

    task automatic test_clear_collision();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        child_valid = 5'b11111;
        repeat (4) cyc();
        n_checks++; if (seen_mask !== 5'b01111) begin n_fail++; $display("FAIL cc_pre_seen got %b want 01111", seen_mask); end
        child_valid = 5'b10000;
        sweep_clr = 1'b1;
        cyc();
        sweep_clr = 1'b0;
        child_valid = 5'b00000;
        n_checks++; if (seen_mask !== 5'b10000) begin n_fail++; $display("FAIL cc_seen got %b want 10000", seen_mask); end
        n_checks++; if (sweep_done !== 1'b0) begin n_fail++; $display("FAIL cc_done got %0b want 0", sweep_done); end
        n_checks++; if (up_src !== 3'd4) begin n_fail++; $display("FAIL cc_src got %0d want 4", up_src); end
        cyc();
    endtask

    task automatic test_saturation();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        child_valid = 5'b11111;
        up_ready = 1'b1;
        repeat (21) cyc();
        n_checks++; if (s_beat_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_cnt4 got %0d want 15", s_beat_cnt); end
        n_checks++; if (beat_cnt !== 16'd20) begin n_fail++; $display("FAIL sat_cnt16 got %0d want 20", beat_cnt); end
        n_checks++; if (up_valid !== 1'b1) begin n_fail++; $display("FAIL sat_pre_rst_valid got %0b want 1", up_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (child_ready !== 5'b00000) begin n_fail++; $display("FAIL midrst_ready got %b want 00000", child_ready); end
        cyc();
        n_checks++; if (up_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %0b want 0", up_valid); end
        n_checks++; if (beat_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_cnt got %0d want 0", beat_cnt); end
        n_checks++; if (s_beat_cnt !== 4'd0) begin n_fail++; $display("FAIL midrst_cnt4 got %0d want 0", s_beat_cnt); end
        n_checks++; if (s_up_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid4 got %0b want 0", s_up_valid); end
        rst_n = 1'b1;
        child_valid = 5'b00000;
        cyc();
    endtask

    initial begin
        rst_n       = 1'b0;
        child_valid = '0;
        child_data  = '0;
        up_ready    = 1'b1;
        sweep_clr   = 1'b0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_sparse_wrap();
        test_clear_collision();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hier_fanin_collector.md
Name: hier_fanin_collector

Overview:
- Fan-in counterpart of the generated parent-to-children instance trees: merges result beats from N_CHILD child instances into one upstream valid/ready channel toward the parent.
- Round-robin arbitration, registered output stage, source tagging, and per-sweep completion tracking.
- The parent knows when every child has reported at least once.

Parameters:
- N_CHILD, 5, number of child channels (2..8).
- DATA_W, 16, payload width per beat.
- SRC_W, 3, width of source index; must satisfy 2**SRC_W >= N_CHILD.
- CNT_W, 16, width of saturating accepted-beat counter.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous active-low reset.
- child_valid  in  N_CHILD  per-child beat valid.
- child_data  in  N_CHILD*DATA_W  packed payloads; child i at bits [i*DATA_W +: DATA_W].
- child_ready  out  N_CHILD  per-child accept; one-hot or zero.
- up_valid  out  1  upstream beat valid.
- up_data  out  DATA_W  upstream payload.
- up_src  out  SRC_W  index of child that produced up_data.
- up_ready  in  1  upstream accept.
- sweep_clr  in  1  clears the seen mask.
- seen_mask  out  N_CHILD  children accepted since last clear/completion.
- sweep_done  out  1  one-cycle pulse when the mask completes.
- beat_cnt  out  CNT_W  total upstream handshakes, saturating.

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-low; clk and rst_n are sampled on the rising edge.
- Reset values: up_valid=0, up_data=0, up_src=0, seen_mask=0, sweep_done=0, beat_cnt=0, rr_ptr=0. child_ready=0 while rst_n=0.
- Reset mid-operation: any held beat is discarded. Children observe child_ready=0 and must keep their beats pending.
- Load enable: load_en = !up_valid || up_ready. The output register accepts a new beat when empty or draining in the same cycle.
- Arbitration:
  - Combinational grant, searching child_valid starting at rr_ptr, ascending with wrap (N_CHILD-1 -> 0).
  - child_ready[i] = grant[i] && load_en.
  - child_ready must not depend on child_valid of other children beyond the priority search.
  - child_ready must not depend on up_valid/up_ready beyond load_en.
- Child handshake (child_valid[i] && child_ready[i]):
  - Next cycle: up_valid=1, up_data=child_data[i], up_src=i.
  - rr_ptr <= (i+1) mod N_CHILD.
  - Latency is exactly 1 cycle. Full throughput is 1 beat/cycle when up_ready is held high.
- No grant while load_en=1: up_valid <= 0 if up_ready consumed the held beat; rr_ptr unchanged.
- Hold rule: while up_valid && !up_ready, up_data/up_src are stable and child_ready=0.
- Fairness: with all children continuously valid and up_ready=1, the grant order is 0,1,2,3,4,0,...
- beat_cnt: increments on each up_valid && up_ready; saturates at 2**CNT_W-1 without wrapping.
- seen_mask / sweep_done:
  - next = (sweep_clr ? 0 : seen_mask) | (handshake ? onehot(i) : 0). A handshake in the same cycle as sweep_clr is retained.
  - If next == all-ones: sweep_done <= 1 for one cycle and seen_mask <= 0.
  - Otherwise seen_mask <= next.
  - For N_CHILD=1 every handshake pulses sweep_done.
- Width rule: up_src is the zero-extended child index.
- Any child_data bits not granted are ignored.

Decomposition:
- Package hier_collect_pkg:
  - default N_CHILD/DATA_W/SRC_W/CNT_W constants;
  - function rr_pick(valid, ptr) returning index plus found flag;
  - typedef for the beat struct {src, data}.
- One sub-module is natural: rr_arbiter (valid vector + pointer in -> one-hot grant + index out), purely combinational, reused by future fan-in blocks.
- Output register, counter, and mask logic stay in the top.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles with child_valid=5'b11111 -> all outputs 0, child_ready=0; after release, first grant goes to child 0.
- Round-robin throughput: all valid, data_i=16'hA000+i, up_ready=1 -> up_src sequence 0,1,2,3,4,0 on consecutive cycles; up_data matches; sweep_done pulses on the cycle after the child-4 beat is accepted; beat_cnt increments by 1 per cycle.
- Backpressure: up_ready=0 for 4 cycles while child 2 holds 16'h1234 -> up_valid=1 with data/src stable, child_ready=0; up_ready=1 -> next beat loads in the same cycle, no bubble.
- Sparse/wrap: only child 3 valid, then only child 1 -> grants 3 then 1, with rr_ptr=4 then 2; seen_mask=5'b01010; no sweep_done.
- Clear collision: seen_mask=5'b01111, sweep_clr=1 in the same cycle as a child-4 handshake -> seen_mask=5'b10000, no pulse.
- Saturation: CNT_W=4, drive 20 beats -> beat_cnt stops at 15. Then rst_n=0 mid-stream -> up_valid drops and beat_cnt=0 on the next edge.
